mem_ring_arbiter: RTL and testbench
===================================

Name: mem_ring_arbiter

Overview:
- Shares the single external memory bus between the four ring-buffer controllers of the dual MIL/SPI core: MIL0 rx, MIL1 rx, SPI->MIL0 tx and SPI->MIL1 tx.
- Accepts single-word read/write requests and grants them round-robin, at most one memory operation per clock.
- Tracks outstanding reads through a latency pipeline and routes read data back to the requester that issued the read.
- Sits between the ring-buffer controllers and the memory bus.

Parameters:
N, 4, number of requesters (2..8)
ADDR_W, 16, memory address width
DATA_W, 16, memory data width
RD_LATENCY, 2, cycles from mem_rd asserted to mem_rdata valid (1..4)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  N  per-requester request; held until ack
we  in  N  per-requester write enable (1=write, 0=read); qualified by req
addr  in  N*ADDR_W  packed request addresses; requester i at [i*ADDR_W +: ADDR_W]
wdata  in  N*DATA_W  packed write data; same packing as addr
ack  out  N  one-cycle pulse: request issued to memory this cycle
rvalid  out  N  one-cycle pulse: rdata holds read result for requester i
rdata  out  DATA_W  read data, shared by all requesters
mem_ready  in  1  memory can accept an operation this cycle
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wr  out  1  memory write strobe
mem_rd  out  1  memory read strobe
mem_rdata  in  DATA_W  memory read data, valid RD_LATENCY cycles after mem_rd

Behaviour:
- Reset (rst=1 at a clk edge):
  - ack, rvalid, mem_wr and mem_rd go to 0.
  - mem_addr, mem_wdata and rdata go to 0.
  - rr_ptr goes to 0.
  - The read-tag pipeline is cleared. Reads in flight at reset never produce rvalid.
- Eligible requesters: elig = req & ~ack. The current ack is masked so a request still high in its ack cycle is not re-granted.
- Arbitration at each edge: if mem_ready=1 and elig is nonzero, the winner w is the first set bit of elig searching from rr_ptr upward, wrapping modulo N.
- All outputs are registered. On the edge after a win, in the same cycle:
  - ack[w]=1.
  - mem_addr and mem_wdata are taken from slot w.
  - mem_wr=we[w] and mem_rd=~we[w].
  - Then rr_ptr = (w+1) mod N.
- No win (mem_ready=0 or elig=0):
  - ack=0, mem_wr=0, mem_rd=0.
  - mem_addr and mem_wdata hold their last values.
  - rr_ptr is unchanged.
- Handshake rules:
  - The requester keeps req, we, addr and wdata stable from req rise until the cycle ack=1 is seen.
  - A new request may be presented the cycle after ack.
  - Per-requester throughput is at most 1 operation per 2 cycles. Aggregate throughput is 1 operation per cycle.
- Read return:
  - A one-hot tag (onehot(w) when mem_rd, else 0) enters a RD_LATENCY-deep shift pipeline in the mem_rd cycle.
  - When the tag emerges, mem_rdata is registered into rdata and rvalid = tag.
  - rvalid therefore rises RD_LATENCY+1 cycles after the ack/mem_rd cycle.
  - Writes produce no rvalid.
- In-flight reads complete regardless of mem_ready and of new grants. Up to RD_LATENCY reads are outstanding. Results return in issue order.
- Fairness: a continuously requesting requester is granted within N grant opportunities.
- Ordering: memory operations are issued in grant order. A write followed by a read to the same address from any requesters returns the written data, provided memory honours order.
- A req drop before ack is legal: the request is withdrawn, with no ack.

Decomposition:
- Shared package (memory bus package): ADDR_W/DATA_W defaults and the memory op enum (MEM_IDLE, MEM_RD, MEM_WR).
- One sub-module, rr_priority_picker: combinational first-set-bit-from-pointer search with wrap. Inputs elig[N] and ptr. Outputs any and a one-hot grant. Reusable by the SPI block selector.

Test Plan:
- Reset mid-read: RD_LATENCY=2, req[1]=1, we[1]=0, addr=0x0041; assert rst the cycle after ack[1] -> rvalid stays 0 for 6 cycles; rr_ptr=0; all outputs 0.
- Single read: req[2]=1, we[2]=0, addr=0x0085, memory returns 0xAB45 -> ack[2] 1 cycle later with mem_rd=1, mem_addr=0x0085; rvalid[2]=1 and rdata=0xAB45 exactly 3 cycles after ack.
- All four requesting continuously (writes, wdata=0x1000+i) -> ack order 0,1,2,3,0,1,...; mem_wr on every cycle after the first grant; no requester granted twice within any window of 4 consecutive grants.
- mem_ready low 5 cycles with req[0] and req[3] pending -> no ack and no mem strobes while low; the first grant goes to the requester at or after rr_ptr; an earlier read still returns its rvalid during the stall.
- Write-then-read hazard: req[0] writes 0xFFA1 to 0x0010 while req[1] reads 0x0010 concurrently -> write issued first (rr_ptr=0); rvalid[1] with rdata=0xFFA1.
- Back-to-back reads from 3 requesters, RD_LATENCY=4 -> rvalid[0], rvalid[1], rvalid[2] on consecutive cycles, each 5 cycles after its ack, with the matching data.

Source files
------------

// File: rtl/mem_ring_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_ring_arbiter_pkg
// Shared definitions for the memory bus between the ring-buffer controllers
// and the external memory: default bus widths and the memory operation
// encoding used to decide the registered read/write strobes.
// -----------------------------------------------------------------------------
package mem_ring_arbiter_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_RD   = 2'd1,
        MEM_WR   = 2'd2
    } mem_op_e;

    // Operation issued for a granted request with the given write enable.
    function automatic mem_op_e op_of(input logic we_bit);
        mem_op_e op;
        if (we_bit) begin
            op = MEM_WR;
        end else begin
            op = MEM_RD;
        end
        return op;
    endfunction

endpackage

// File: rtl/mem_ring_arbiter_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin search: returns a one-hot grant for the first set
// bit of elig_i found when scanning upward from ptr_i and wrapping modulo N.
// Ports:
//   elig_i  [N]      eligible requesters
//   ptr_i   [PTR_W]  index where the search starts (must be < N)
//   any_o            at least one requester is eligible
//   grant_o [N]      one-hot winner, zero when any_o is 0
// -----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int N = 4,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     elig_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             any_o,
    output logic [N-1:0]     grant_o
);

    logic [PTR_W:0]   sum_s;
    logic [PTR_W-1:0] idx_s;

    // Scan offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        any_o   = 1'b0;
        grant_o = '0;
        sum_s   = '0;
        idx_s   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum_s = {1'b0, ptr_i} + (PTR_W + 1)'(k);
            if (sum_s >= (PTR_W + 1)'(N)) begin
                sum_s = sum_s - (PTR_W + 1)'(N);
            end else begin
                sum_s = sum_s;
            end
            idx_s = sum_s[PTR_W-1:0];
            if (elig_i[idx_s]) begin
                grant_o        = '0;
                grant_o[idx_s] = 1'b1;
                any_o          = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/mem_ring_arbiter.sv
// -----------------------------------------------------------------------------
// mem_ring_arbiter
// Shares one memory bus between N ring-buffer controllers. Requests are
// granted round-robin, at most one per clock, and read results are routed
// back to the issuing requester through a one-hot tag pipeline that tracks
// the memory read latency.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req/we/addr/wdata      per-requester request (addr/wdata packed by slot)
//   ack                    one-cycle pulse when the request goes to memory
//   rvalid/rdata           one-cycle read return pulse and shared read data
//   mem_ready              memory accepts an operation this cycle
//   mem_addr/mem_wdata     registered memory address and write data
//   mem_wr/mem_rd          registered memory strobes
//   mem_rdata              read data, valid RD_LATENCY cycles after mem_rd
// -----------------------------------------------------------------------------
module mem_ring_arbiter
    import mem_ring_arbiter_pkg::*;
#(
    parameter int N          = 4,
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int RD_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N-1:0]        we,
    input  logic [N*ADDR_W-1:0] addr,
    input  logic [N*DATA_W-1:0] wdata,
    output logic [N-1:0]        ack,
    output logic [N-1:0]        rvalid,
    output logic [DATA_W-1:0]   rdata,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_wr,
    output logic                mem_rd,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]      elig_s;
    logic [N-1:0]      grant_s;
    logic              any_s;
    logic              win_s;
    logic [PTR_W-1:0]  win_idx_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_we_s;
    logic [N-1:0]      tag_in_s;

    logic [N-1:0]      ack_q, ack_d;
    mem_op_e           op_d;
    logic              mem_wr_q, mem_rd_q;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N-1:0]      tag_q [RD_LATENCY];
    logic [N-1:0]      rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    // A request still high in its ack cycle must not be granted a second time.
    assign elig_s = req & ~ack_q;
    assign win_s  = mem_ready & any_s;

    rr_priority_picker #(
        .N (N)
    ) u_picker (
        .elig_i  (elig_s),
        .ptr_i   (rr_ptr_q),
        .any_o   (any_s),
        .grant_o (grant_s)
    );

    // Decode the one-hot grant into an index and select the winner's slot.
    always_comb begin
        win_idx_s   = '0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        sel_we_s    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_s[i]) begin
                win_idx_s   = PTR_W'(i);
                sel_addr_s  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata_s = wdata[i*DATA_W +: DATA_W];
                sel_we_s    = we[i];
            end else begin
                win_idx_s = win_idx_s;
            end
        end
    end

    // Next-state for the issue stage; the bus holds address/data when idle.
    always_comb begin
        ack_d       = '0;
        op_d        = MEM_IDLE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rr_ptr_d    = rr_ptr_q;
        if (win_s) begin
            ack_d       = grant_s;
            op_d        = op_of(sel_we_s);
            mem_addr_d  = sel_addr_s;
            mem_wdata_d = sel_wdata_s;
            if (win_idx_s == PTR_W'(N - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = win_idx_s + PTR_W'(1);
            end
        end else begin
            op_d = MEM_IDLE;
        end
    end

    // Issue-stage registers driving the memory bus and the ack pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q       <= '0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            ack_q       <= ack_d;
            mem_wr_q    <= (op_d == MEM_WR);
            mem_rd_q    <= (op_d == MEM_RD);
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // The tag of the requester whose read is on the bus this cycle.
    always_comb begin
        if (mem_rd_q) begin
            tag_in_s = ack_q;
        end else begin
            tag_in_s = '0;
        end
    end

    // Tag pipeline: a tag leaves the last stage in the cycle mem_rdata is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            tag_q[0] <= tag_in_s;
            for (int k = 1; k < RD_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            rvalid_q <= tag_q[RD_LATENCY-1];
            if (|tag_q[RD_LATENCY-1]) begin
                rdata_q <= mem_rdata;
            end else begin
                rdata_q <= rdata_q;
            end
        end
    end

    assign ack       = ack_q;
    assign mem_wr    = mem_wr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_ring_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_ring_arbiter
// Two arbiters (read latency 2 and 4) share the same request stimulus; each
// has its own memory model. Expected grants and read returns are queued when
// stimulus is issued and popped by a monitor when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_mem_ring_arbiter;

    localparam int N     = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int LAT_A = 2;
    localparam int LAT_B = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [N-1:0]  req, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic          mem_ready;

    logic [N-1:0]  ack_a, rvalid_a, ack_b, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b, mem_wdata_a, mem_wdata_b, mem_rdata_a, mem_rdata_b;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic          mem_wr_a, mem_rd_a, mem_wr_b, mem_rd_b;

    mem_ring_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack_a), .rvalid(rvalid_a), .rdata(rdata_a), .mem_ready(mem_ready),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_wr(mem_wr_a),
        .mem_rd(mem_rd_a), .mem_rdata(mem_rdata_a)
    );

    mem_ring_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack_b), .rvalid(rvalid_b), .rdata(rdata_b), .mem_ready(mem_ready),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_wr(mem_wr_b),
        .mem_rd(mem_rd_b), .mem_rdata(mem_rdata_b)
    );

    // ---------------- memory models ----------------
    function automatic logic [DW-1:0] preload(input logic [7:0] a);
        case (a)
            8'h30:   return 16'h5A5A;
            8'h32:   return 16'h3C3C;
            8'h41:   return 16'h4141;
            8'h50:   return 16'h1111;
            8'h51:   return 16'h2222;
            8'h52:   return 16'h3333;
            8'h85:   return 16'hAB45;
            default: return 16'h0000;
        endcase
    endfunction

    logic [DW-1:0] mem_a [0:255];
    logic [DW-1:0] mem_b [0:255];
    logic [DW-1:0] pipe_a [0:LAT_A-1];
    logic [DW-1:0] pipe_b [0:LAT_B-1];
    logic          init_a, init_b;

    always @(posedge clk) begin
        if (init_a !== 1'b1) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= preload(8'(i));
            init_a <= 1'b1;
        end else if (mem_wr_a === 1'b1) begin
            mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
        end
        pipe_a[0] <= (mem_rd_a === 1'b1) ? mem_a[mem_addr_a[7:0]] : 16'hDEAD;
        for (int k = 1; k < LAT_A; k++) pipe_a[k] <= pipe_a[k-1];
    end
    assign mem_rdata_a = pipe_a[LAT_A-1];

    always @(posedge clk) begin
        if (init_b !== 1'b1) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= preload(8'(i));
            init_b <= 1'b1;
        end else if (mem_wr_b === 1'b1) begin
            mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
        end
        pipe_b[0] <= (mem_rd_b === 1'b1) ? mem_b[mem_addr_b[7:0]] : 16'hDEAD;
        for (int k = 1; k < LAT_B; k++) pipe_b[k] <= pipe_b[k-1];
    end
    assign mem_rdata_b = pipe_b[LAT_B-1];

    // ---------------- scoreboard ----------------
    typedef struct {
        int            id;
        bit            is_wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ack_exp_t;

    typedef struct {
        int            id;
        logic [DW-1:0] d;
    } rd_exp_t;

    ack_exp_t exp_ack_q [2][$];
    rd_exp_t  exp_rd_q  [2][$];
    int       lat_q     [2][$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int d, input int lat, input logic [N-1:0] ack_v,
                       input logic [N-1:0] rv_v, input logic [DW-1:0] rd_v,
                       input logic [AW-1:0] ma, input logic [DW-1:0] mwd,
                       input logic mwr, input logic mrd);
        ack_exp_t ea;
        rd_exp_t  er;
        int       t0;
        string    p;
        p = (d == 0) ? "A" : "B";
        if (ack_v != '0) begin
            if (exp_ack_q[d].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_unexpected_ack: got %b expected none", p, ack_v);
            end else begin
                ea = exp_ack_q[d].pop_front();
                check({p, "_ack"}, 32'(ack_v), 32'(1) << ea.id);
                check({p, "_mem_wr"}, 32'(mwr), 32'(ea.is_wr));
                check({p, "_mem_rd"}, 32'(mrd), 32'(!ea.is_wr));
                check({p, "_mem_addr"}, 32'(ma), 32'(ea.a));
                if (ea.is_wr) check({p, "_mem_wdata"}, 32'(mwd), 32'(ea.d));
                else lat_q[d].push_back(cyc);
            end
        end
        if (rv_v != '0) begin
            if (exp_rd_q[d].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_unexpected_rvalid: got %b expected none", p, rv_v);
            end else begin
                er = exp_rd_q[d].pop_front();
                check({p, "_rvalid"}, 32'(rv_v), 32'(1) << er.id);
                check({p, "_rdata"}, 32'(rd_v), 32'(er.d));
                if (lat_q[d].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s_latency: got rvalid with no read issued expected a read", p);
                end else begin
                    t0 = lat_q[d].pop_front();
                    check({p, "_latency"}, 32'(cyc - t0), 32'(lat + 1));
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, LAT_A, ack_a, rvalid_a, rdata_a, mem_addr_a, mem_wdata_a, mem_wr_a, mem_rd_a);
        mon(1, LAT_B, ack_b, rvalid_b, rdata_b, mem_addr_b, mem_wdata_b, mem_wr_b, mem_rd_b);
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int id, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[id] = 1'b1;
        we[id]  = w;
        addr[id*AW +: AW]  = a;
        wdata[id*DW +: DW] = d;
    endtask

    task automatic exp_grant(input int id, input bit is_wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input bit want_rv, input logic [DW-1:0] rv);
        ack_exp_t ea;
        rd_exp_t  er;
        ea.id = id; ea.is_wr = is_wr; ea.a = a; ea.d = d;
        er.id = id; er.d = rv;
        for (int dd = 0; dd < 2; dd++) begin
            exp_ack_q[dd].push_back(ea);
            if (want_rv) exp_rd_q[dd].push_back(er);
        end
    endtask

    // Drop each request in its ack cycle until none remain, within a budget.
    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (req != '0 && n < budget) begin
            @(negedge clk);
            req = req & ~ack_a;
            n++;
        end
        check("drain_timeout", 32'(req), 32'h0);
        req = '0;
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_ack"},    32'({ack_a, ack_b}), 32'h0);
        check({nm, "_rvalid"}, 32'({rvalid_a, rvalid_b}), 32'h0);
        check({nm, "_strobe"}, 32'({mem_wr_a, mem_rd_a, mem_wr_b, mem_rd_b}), 32'h0);
        check({nm, "_maddr"},  32'({mem_addr_a, mem_addr_b}), 32'h0);
        check({nm, "_mwdata"}, 32'({mem_wdata_a, mem_wdata_b}), 32'h0);
        check({nm, "_rdata"},  32'({rdata_a, rdata_b}), 32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit seen_a, seen_b;
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Reset while a read is in flight: that read never returns.
        @(negedge clk);
        set_req(1, 1'b0, 16'h0041, 16'h0000);
        exp_grant(1, 1'b0, 16'h0041, 16'h0000, 1'b0, 16'h0000);
        wait_drain(10);
        @(negedge clk);
        lat_q[0].delete();
        lat_q[1].delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midread_reset");
        repeat (6) begin
            @(negedge clk);
            check("midread_no_rvalid", 32'({rvalid_a, rvalid_b}), 32'h0);
        end

        // All four writing continuously: rotation starts at 0 after reset.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 16'(16'h0020 + i), 16'(16'h1000 + i));
        for (int k = 0; k < 8; k++)
            exp_grant(k % N, 1'b1, 16'(16'h0020 + k % N), 16'(16'h1000 + k % N), 1'b0, 16'h0000);
        repeat (8) begin
            @(negedge clk);
            check("cont_mem_wr", 32'({mem_wr_a, mem_wr_b}), 32'h3);
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Back-to-back reads from requesters 0,1,2 (pointer at 0).
        set_req(0, 1'b0, 16'h0050, 16'h0000);
        set_req(1, 1'b0, 16'h0051, 16'h0000);
        set_req(2, 1'b0, 16'h0052, 16'h0000);
        exp_grant(0, 1'b0, 16'h0050, 16'h0000, 1'b1, 16'h1111);
        exp_grant(1, 1'b0, 16'h0051, 16'h0000, 1'b1, 16'h2222);
        exp_grant(2, 1'b0, 16'h0052, 16'h0000, 1'b1, 16'h3333);
        wait_drain(20);
        repeat (8) @(negedge clk);

        // Stall: pointer at 3; read from 3 then memory not ready for 5 cycles.
        set_req(3, 1'b0, 16'h0030, 16'h0000);
        exp_grant(3, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h5A5A);
        wait_drain(10);
        mem_ready = 1'b0;
        set_req(0, 1'b1, 16'h0031, 16'h0C0C);
        set_req(3, 1'b0, 16'h0032, 16'h0000);
        exp_grant(0, 1'b1, 16'h0031, 16'h0C0C, 1'b0, 16'h0000);
        exp_grant(3, 1'b0, 16'h0032, 16'h0000, 1'b1, 16'h3C3C);
        seen_a = 1'b0;
        seen_b = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_quiet_a", 32'({ack_a, mem_wr_a, mem_rd_a}), 32'h0);
            check("stall_quiet_b", 32'({ack_b, mem_wr_b, mem_rd_b}), 32'h0);
            if (rvalid_a != '0) seen_a = 1'b1;
            if (rvalid_b != '0) seen_b = 1'b1;
        end
        check("stall_rvalid_a", 32'(seen_a), 32'h1);
        check("stall_rvalid_b", 32'(seen_b), 32'h1);
        mem_ready = 1'b1;
        wait_drain(10);
        repeat (8) @(negedge clk);

        // Write-then-read hazard on 0x0010 with the pointer at 0.
        set_req(0, 1'b1, 16'h0010, 16'hFFA1);
        set_req(1, 1'b0, 16'h0010, 16'h0000);
        exp_grant(0, 1'b1, 16'h0010, 16'hFFA1, 1'b0, 16'h0000);
        exp_grant(1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hFFA1);
        wait_drain(10);
        repeat (8) @(negedge clk);

        // Single read from requester 2.
        set_req(2, 1'b0, 16'h0085, 16'h0000);
        exp_grant(2, 1'b0, 16'h0085, 16'h0000, 1'b1, 16'hAB45);
        wait_drain(10);
        repeat (8) @(negedge clk);

        for (int dd = 0; dd < 2; dd++) begin
            check("pending_acks", 32'(exp_ack_q[dd].size()), 32'h0);
            check("pending_reads", 32'(exp_rd_q[dd].size()), 32'h0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
